// File: rtl/inst_fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage.
package inst_fetch_stage_pkg;

  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned CNT_WIDTH        = 32;
  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds, otherwise loads.
module inst_fetch_stage_if_id_reg
  import inst_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   stall,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_plus4_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc_plus4,
  output logic                   valid
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      instr    <= INSTR_WIDTH'(NOP_INSTR);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!stall) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select, IF/ID register.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter int unsigned        PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_f,
  input  logic                   flush_d,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    pc_f,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                   if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]   fetch_cnt,
  output logic [CNT_WIDTH-1:0]   stall_cnt,
  output logic [CNT_WIDTH-1:0]   redirect_cnt,
`endif
  output logic                   misalign_err
);

  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] target_aligned;
  logic [PC_WIDTH-1:0] pc_plus4;

  // Jump has priority over a simultaneously taken branch.
  always_comb begin
    redirect       = jump | branch_taken;
    target         = jump ? jump_target : branch_target;
    target_aligned = {target[PC_WIDTH-1:2], 2'b00};
    pc_plus4       = pc_f + PC_WIDTH'(PC_INC);
  end

  assign imem_addr = pc_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f <= RESET_PC;
    end else if (redirect) begin
      pc_f <= target_aligned;
    end else if (!stall_f) begin
      pc_f <= pc_plus4;
    end
  end

  // Sticky until reset; the PC still takes the word-aligned target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect && (target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  inst_fetch_stage_if_id_reg #(
    .PC_WIDTH (PC_WIDTH)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush_d | redirect),
    .stall       (stall_f),
    .instr_in    (imem_rdata),
    .pc_plus4_in (pc_plus4),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic load_valid;
  assign load_valid = !flush_d && !redirect && !stall_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt    <= '0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (load_valid)          fetch_cnt    <= fetch_cnt + CNT_WIDTH'(1);
      if (stall_f && !redirect) stall_cnt   <= stall_cnt + CNT_WIDTH'(1);
      if (redirect)            redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed scenarios plus random traffic against a behavioural model.
module tb_inst_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        flush_d;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] redirect_cnt;
  logic [31:0] m_fetch_cnt, m_stall_cnt, m_redirect_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis;

  inst_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_f        (stall_f),
    .flush_d        (flush_d),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc_f           (pc_f),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt),
    .redirect_cnt   (redirect_cnt),
`endif
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0007;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  // One clock: drive at negedge, advance the model, sample 1 time unit after posedge.
  task automatic step(input logic r, input logic s, input logic f, input logic b,
                      input logic [31:0] bt, input logic j, input logic [31:0] jt);
    logic        redir;
    logic [31:0] tgt;
    @(negedge clk);
    rst_n = r; stall_f = s; flush_d = f;
    branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    redir = j | b;
    tgt   = j ? jt : bt;
    if (!r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      m_fetch_cnt = 0; m_stall_cnt = 0; m_redirect_cnt = 0;
`endif
    end else begin
`ifdef FETCH_PERF_CNT_EN
      if (!f && !redir && !s) m_fetch_cnt++;
      if (s && !redir)        m_stall_cnt++;
      if (redir)              m_redirect_cnt++;
`endif
      if (f || redir) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (redir && (tgt % 4 != 0)) m_mis = 1'b1;
      if (redir)    m_pc = tgt - (tgt % 4);
      else if (!s)  m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1, 1'b1, 1'b1, $urandom, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0, $urandom);
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_f, 32'h0); end
    checks++; if (if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ifid: got instr=%h pc4=%h v=%b want 0/0/0", if_id_instr, if_id_pc_plus4, if_id_valid);
    end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misalign_err); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h want 4", pc_f); end
    checks++; if (if_id_instr !== 32'h2008_0005 || if_id_pc_plus4 !== 32'h4 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL seq_first: got instr=%h pc4=%h v=%b want 20080005/4/1", if_id_instr, if_id_pc_plus4, if_id_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'h8 || if_id_instr !== 32'h2009_0007 || if_id_pc_plus4 !== 32'h8) begin
      errors++; $display("FAIL seq_second: got pc=%h instr=%h pc4=%h want 8/20090007/8", pc_f, if_id_instr, if_id_pc_plus4);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++; if (pc_f !== 32'h8 || if_id_instr !== 32'h2009_0007 || if_id_pc_plus4 !== 32'h8 || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got pc=%h instr=%h pc4=%h v=%b want 8/20090007/8/1", i, pc_f, if_id_instr, if_id_pc_plus4, if_id_valid);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'hC || if_id_instr !== mem_word(32'h8) || if_id_pc_plus4 !== 32'hC) begin
      errors++; $display("FAIL stall_resume: got pc=%h instr=%h pc4=%h want c/%h/c", pc_f, if_id_instr, if_id_pc_plus4, mem_word(32'h8));
    end
  endtask

  task automatic test_redirect_over_stall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] rc0;
    rc0 = redirect_cnt;
`endif
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h want 40", pc_f); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL branch_bubble: got instr=%h pc4=%h v=%b want 0/0/0", if_id_instr, if_id_pc_plus4, if_id_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (redirect_cnt !== rc0 + 32'd1) begin errors++; $display("FAIL branch_cnt: got %0d want %0d", redirect_cnt, rc0 + 32'd1); end
`endif
  endtask

  task automatic test_jump_priority;
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0100);
    checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL jump_prio: got %h want 100", pc_f); end
    // plain flush still advances the PC
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'h104 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL flush_adv: got pc=%h v=%b want 104/0", pc_f, if_id_valid);
    end
  endtask

  task automatic test_misalign;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102);
    checks++; if (pc_f !== 32'h100 || misalign_err !== 1'b1) begin
      errors++; $display("FAIL misalign_set: got pc=%h err=%b want 100/1", pc_f, misalign_err);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b want 1", misalign_err); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'h0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_in_stall: got pc=%h err=%b want 0/0", pc_f, misalign_err);
    end
  endtask

  task automatic test_wrap;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump: got %h want fffffffc", pc_f); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (pc_f !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_pc: got pc=%h pc4=%h v=%b instr=%h want 0/0/1/%h", pc_f, if_id_pc_plus4, if_id_valid, if_id_instr, mem_word(32'hFFFF_FFFC));
    end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL wrap_mis: got %b want 0", misalign_err); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom; jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, bt, $urandom_range(0, 9) == 0, jt);
      checks++;
      if (pc_f !== m_pc || imem_addr !== m_pc || if_id_instr !== m_instr || if_id_pc_plus4 !== m_pc4 ||
          if_id_valid !== m_valid || misalign_err !== m_mis) begin
        errors++;
        $display("FAIL random[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b err=%b want pc=%h instr=%h pc4=%h v=%b err=%b",
                 i, pc_f, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, misalign_err,
                 m_pc, m_instr, m_pc4, m_valid, m_mis);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fetch_cnt !== m_fetch_cnt || stall_cnt !== m_stall_cnt || redirect_cnt !== m_redirect_cnt) begin
        errors++;
        $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, fetch_cnt, stall_cnt, redirect_cnt,
                 m_fetch_cnt, m_stall_cnt, m_redirect_cnt);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_f = 1'b0; flush_d = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_over_stall;
    test_jump_priority;
    test_misalign;
    test_wrap;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Fetch stage immediately upstream of the combinational instruction memory in the 5-stage pipelined MIPS core.
- Owns the program counter and computes next-PC from sequential, branch and jump sources.
- Drives the word address into instruction memory, takes the returned instruction in the same cycle, and registers it with PC+4 into the IF/ID pipeline register.
- Responds to hazard-unit stall and flush controls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_WIDTH, 32, width of PC and all address/target ports.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- stall_f  input  1  hazard unit: hold PC and IF/ID
- flush_d  input  1  hazard unit: replace IF/ID contents with a bubble
- branch_taken  input  1  branch resolved taken in ID
- branch_target  input  PC_WIDTH  branch destination byte address
- jump  input  1  jump (j/jal/jr) resolved in ID
- jump_target  input  PC_WIDTH  jump destination byte address
- imem_addr  output  PC_WIDTH  byte address to instruction memory (= pc)
- imem_rdata  input  32  instruction word from instruction memory (combinational)
- pc_f  output  PC_WIDTH  current fetch PC
- if_id_instr  output  32  registered instruction
- if_id_pc_plus4  output  PC_WIDTH  registered PC+4 of that instruction
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- misalign_err  output  1  sticky: a redirect target had addr[1:0] != 0

Behaviour:
- Reset (rst_n=0 at posedge): pc_f=RESET_PC, if_id_instr=32'h0 (nop), if_id_pc_plus4=0, if_id_valid=0, misalign_err=0.
  - Reset overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr = pc_f (combinational); the instruction is captured into IF/ID at the same edge, so fetch latency is 1 cycle from PC to if_id_instr.
- Redirect: redirect = jump | branch_taken.
  - Target select: jump_target if jump=1, otherwise branch_target; jump wins if both are asserted.
- PC update priority per edge (first match):
  - reset
  - redirect: pc <= {target[31:2],2'b00}
  - stall_f: pc holds
  - else: pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0, no error).
- IF/ID update priority per edge (first match):
  - reset
  - flush_d or redirect: bubble (instr=0, pc_plus4=0, valid=0); the wrong-path fetch is discarded
  - stall_f: hold all three fields
  - else: instr <= imem_rdata, pc_plus4 <= pc_f+4, valid <= 1.
- Redirect overrides stall_f for both PC and IF/ID.
- flush_d without redirect advances the PC normally unless stall_f is also asserted.
- misalign_err: set at any edge where redirect=1 and selected target[1:0] != 0; stays set until reset.
  - The PC still takes the aligned target.
- No handshake with memory; memory is assumed zero-wait combinational by design contract.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds 32-bit output ports fetch_cnt, stall_cnt, redirect_cnt, all reset to 0.
  - fetch_cnt increments on each edge where IF/ID loads a valid instruction.
  - stall_cnt increments on each edge where stall_f=1 and redirect=0.
  - redirect_cnt increments on each redirect edge.
  - Counters wrap modulo 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared header fetch_defs.vh holds:
  - NOP_INSTR = 32'h0000_0000
  - PC_INC = 4
  - DEFAULT_RESET_PC = 32'h0000_0000
- One natural sub-module: if_id_reg (instr, pc_plus4, valid with flush/stall priority).
- PC register and next-PC mux stay in the top.

Test Plan:
- Reset release, no stall, imem returns 0x20080005 at address 0 and 0x20090007 at address 4:
  - pc_f sequence 0,4,8.
  - if_id_instr is 0x20080005 one cycle after pc_f=0, with pc_plus4=4, valid=1.
- stall_f high 2 cycles while pc_f=8: pc_f stays 8 and IF/ID holds its previous contents for 2 edges, then resumes with pc 12.
- branch_taken=1, branch_target=0x40, with stall_f=1 at the same edge: next pc_f=0x40, IF/ID valid=0 with instr=0, redirect_cnt+1 when the feature is enabled.
- jump=1 with jump_target=0x100 and branch_taken=1 with branch_target=0x80 at the same edge: pc_f=0x100.
- jump_target=0x102: pc_f=0x100, misalign_err=1 and stays 1 until rst_n pulses low; reset asserted during a stall returns pc_f to RESET_PC.
- Force pc_f=0xFFFF_FFFC via jump: next pc_f=0, if_id_pc_plus4=0, misalign_err unchanged.
